// File: rtl/ecc_scrub_pkg.sv
// Shared types and helpers for the ECC scrubber and its SECDED codec.
package ecc_scrub_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      RD_REQ,
      RD_WAIT,
      CHECK,
      WR_REQ,
      NEXT
   } scrub_state_e;

   // Smallest m with 2**m >= m+k+1.
   function automatic int calculate_m(input int k);
      int m;
      m = 1;
      while ((1 << m) < (m + k + 1)) m = m + 1;
      return m;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/ecc_dec.sv
// Hamming SECDED decoder: corrects one flipped bit, flags two flipped bits.
module ecc_dec
   import ecc_scrub_pkg::*;
#(
   parameter int K      = 8,
   parameter int P0_LSB = 1,
   localparam int M     = calculate_m(K),
   localparam int N     = M + K
) (
   input  logic [N:0]   code_i,
   output logic [K-1:0] data_o,
   output logic         sbe_o,
   output logic         dbe_o
);

   logic [N:1]   h;
   logic [N:1]   hc;
   logic         p0;
   logic         par;
   logic [M-1:0] syn;

   always_comb begin
      int d;
      if (P0_LSB != 0) begin
         h  = code_i[N:1];
         p0 = code_i[0];
      end else begin
         h  = code_i[N-1:0];
         p0 = code_i[N];
      end
      syn = '0;
      for (int j = 1; j <= N; j++) begin
         if (h[j]) syn ^= M'(j);
      end
      par = p0 ^ (^h);
      // Odd parity with a syndrome past the last position cannot be one flip.
      sbe_o = par && (int'(syn) <= N);
      dbe_o = (!par && (syn != '0)) || (par && (int'(syn) > N));
      hc = h;
      if (sbe_o && (syn != '0)) hc[syn] = ~hc[syn];
      data_o = '0;
      d = 0;
      for (int j = 1; j <= N; j++) begin
         if ((j & (j - 1)) != 0) begin
            data_o[d] = hc[j];
            d = d + 1;
         end
      end
   end

endmodule

// File: rtl/ecc_enc.sv
// Hamming SECDED encoder: check bits at power-of-two positions, extended parity p0.
module ecc_enc
   import ecc_scrub_pkg::*;
#(
   parameter int K      = 8,
   parameter int P0_LSB = 1,
   localparam int M     = calculate_m(K),
   localparam int N     = M + K
) (
   input  logic [K-1:0] data_i,
   output logic [N:0]   code_o
);

   logic [N:1] h;
   logic       p0;

   always_comb begin
      int d;
      h = '0;
      d = 0;
      for (int j = 1; j <= N; j++) begin
         if ((j & (j - 1)) != 0) begin
            h[j] = data_i[d];
            d = d + 1;
         end
      end
      for (int i = 0; i < M; i++) begin
         for (int j = 1; j <= N; j++) begin
            if ((((j >> i) & 1) != 0) && (j != (1 << i))) h[1 << i] ^= h[j];
         end
      end
      p0 = ^h;
      code_o = (P0_LSB != 0) ? {h, p0} : {p0, h};
   end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Background scrubber: reads each word, rewrites corrected single-bit errors,
// reports double-bit errors. Memory port is shared through a req/gnt arbiter.
module ecc_scrub_ctrl
   import ecc_scrub_pkg::*;
#(
   parameter int K      = 8,
   parameter int DEPTH  = 1024,
   parameter int AW     = $clog2(DEPTH),
   parameter int P0_LSB = 1,
   localparam int M     = calculate_m(K),
   localparam int N     = M + K
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          en_i,
   input  logic [15:0]   interval_i,
   input  logic          clr_cnt_i,
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [N:0]    mem_wdata_o,
   input  logic          mem_gnt_i,
   input  logic          mem_rvalid_i,
   input  logic [N:0]    mem_rdata_i,
   output logic          busy_o,
   output logic [15:0]   sbe_cnt_o,
   output logic [15:0]   dbe_cnt_o,
   output logic          dbe_o,
   output logic [AW-1:0] dbe_addr_o,
   output logic          pass_done_o
);

   // Handshake: a request (req=1) holds we/addr/wdata stable until the cycle
   // gnt=1 is seen; read data is taken on the first rvalid after the gnt cycle.

   scrub_state_e  state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [15:0]   timer_q, timer_d;
   logic [N:0]    code_q, code_d;
   logic [N:0]    wdata_q, wdata_d;
   logic [15:0]   sbe_cnt_q, sbe_cnt_d;
   logic [15:0]   dbe_cnt_q, dbe_cnt_d;
   logic          dbe_q, dbe_d;
   logic [AW-1:0] dbe_addr_q, dbe_addr_d;
   logic          pass_done_q, pass_done_d;

   logic [K-1:0]  dec_data;
   logic          dec_sbe;
   logic          dec_dbe;
   logic [N:0]    enc_code;

   ecc_dec #(.K(K), .P0_LSB(P0_LSB)) u_dec (
      .code_i (code_q),
      .data_o (dec_data),
      .sbe_o  (dec_sbe),
      .dbe_o  (dec_dbe)
   );

   ecc_enc #(.K(K), .P0_LSB(P0_LSB)) u_enc (
      .data_i (dec_data),
      .code_o (enc_code)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      timer_d     = timer_q;
      code_d      = code_q;
      wdata_d     = wdata_q;
      sbe_cnt_d   = sbe_cnt_q;
      dbe_cnt_d   = dbe_cnt_q;
      dbe_d       = 1'b0;
      dbe_addr_d  = dbe_addr_q;
      pass_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (en_i) begin
               timer_d = interval_i;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (!en_i) state_d = IDLE;
            else if (timer_q == 16'd0) state_d = RD_REQ;
            else timer_d = timer_q - 16'd1;
         end
         RD_REQ: begin
            if (mem_gnt_i) state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (mem_rvalid_i) begin
               code_d  = mem_rdata_i;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (dec_sbe) begin
               sbe_cnt_d = sat_inc16(sbe_cnt_q);
               wdata_d   = enc_code;
               state_d   = WR_REQ;
            end else begin
               if (dec_dbe) begin
                  dbe_cnt_d  = sat_inc16(dbe_cnt_q);
                  dbe_d      = 1'b1;
                  dbe_addr_d = ptr_q;
               end
               state_d = NEXT;
            end
         end
         WR_REQ: begin
            if (mem_gnt_i) state_d = NEXT;
         end
         NEXT: begin
            if (ptr_q == AW'(DEPTH - 1)) begin
               ptr_d       = '0;
               pass_done_d = 1'b1;
            end else begin
               ptr_d = ptr_q + AW'(1);
            end
            if (en_i) begin
               timer_d = interval_i;
               state_d = WAIT;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A clear landing on the same cycle as an increment wins.
      if (clr_cnt_i) begin
         sbe_cnt_d = '0;
         dbe_cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         timer_q     <= '0;
         code_q      <= '0;
         wdata_q     <= '0;
         sbe_cnt_q   <= '0;
         dbe_cnt_q   <= '0;
         dbe_q       <= 1'b0;
         dbe_addr_q  <= '0;
         pass_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         timer_q     <= timer_d;
         code_q      <= code_d;
         wdata_q     <= wdata_d;
         sbe_cnt_q   <= sbe_cnt_d;
         dbe_cnt_q   <= dbe_cnt_d;
         dbe_q       <= dbe_d;
         dbe_addr_q  <= dbe_addr_d;
         pass_done_q <= pass_done_d;
      end
   end

   assign mem_req_o   = (state_q == RD_REQ) || (state_q == WR_REQ);
   assign mem_we_o    = (state_q == WR_REQ);
   assign mem_addr_o  = ptr_q;
   assign mem_wdata_o = wdata_q;
   assign busy_o      = (state_q != IDLE);
   assign sbe_cnt_o   = sbe_cnt_q;
   assign dbe_cnt_o   = dbe_cnt_q;
   assign dbe_o       = dbe_q;
   assign dbe_addr_o  = dbe_addr_q;
   assign pass_done_o = pass_done_q;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Bench for ecc_scrub_ctrl: memory/arbiter responder plus an access scoreboard.
module tb_ecc_scrub_ctrl;

   localparam int K     = 8;
   localparam int DEPTH = 4;
   localparam int AW    = 2;
   localparam int CW    = 13;
   localparam int W     = 1 + AW + CW;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          en_i = 1'b0;
   logic [15:0]   interval_i = 16'd0;
   logic          clr_cnt_i = 1'b0;
   logic          mem_req_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [CW-1:0] mem_wdata_o;
   logic          mem_gnt_i = 1'b0;
   logic          mem_rvalid_i = 1'b0;
   logic [CW-1:0] mem_rdata_i = '0;
   logic          busy_o;
   logic [15:0]   sbe_cnt_o;
   logic [15:0]   dbe_cnt_o;
   logic          dbe_o;
   logic [AW-1:0] dbe_addr_o;
   logic          pass_done_o;

   always #5 clk = ~clk;

   ecc_scrub_ctrl #(.K(K), .DEPTH(DEPTH), .AW(AW), .P0_LSB(1)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .en_i         (en_i),
      .interval_i   (interval_i),
      .clr_cnt_i    (clr_cnt_i),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .busy_o       (busy_o),
      .sbe_cnt_o    (sbe_cnt_o),
      .dbe_cnt_o    (dbe_cnt_o),
      .dbe_o        (dbe_o),
      .dbe_addr_o   (dbe_addr_o),
      .pass_done_o  (pass_done_o)
   );

   int checks   = 0;
   int failures = 0;

   logic [W-1:0]  exp_q[$];
   logic [CW-1:0] mem[DEPTH];

   int            gnt_delay = 1;
   int            age = 0;
   logic          rd_pend = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   int            acc_cnt = 0;
   int            cyc = 0;
   int            last_acc_cyc = 0;
   int            prev_acc_cyc = 0;
   int            pd_seen = 0;
   int            pd_at_acc = 0;
   int            dbe_seen = 0;

   // Reference SECDED encoding for K=8, p0 in bit 0, written out bit by bit.
   function automatic logic [CW-1:0] ref_enc(input logic [7:0] d);
      logic [CW-1:0] c;
      c = '0;
      c[3]  = d[0];
      c[5]  = d[1];
      c[6]  = d[2];
      c[7]  = d[3];
      c[9]  = d[4];
      c[10] = d[5];
      c[11] = d[6];
      c[12] = d[7];
      c[1]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
      c[2]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
      c[4]  = d[1] ^ d[2] ^ d[3] ^ d[7];
      c[8]  = d[4] ^ d[5] ^ d[6] ^ d[7];
      c[0]  = ^c[12:1];
      return c;
   endfunction

   function automatic logic [W-1:0] mk(input logic we, input logic [AW-1:0] a,
                                       input logic [CW-1:0] d);
      return {we, a, d};
   endfunction

   // Arbiter + memory model: gnt after gnt_delay cycles of request, rvalid one
   // cycle after a read grant. Every granted access is scored against exp_q.
   always @(negedge clk) begin : responder
      logic [W-1:0] obs;
      logic [W-1:0] exp_v;
      cyc = cyc + 1;
      mem_rvalid_i = 1'b0;
      if (rd_pend) begin
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = mem[rd_addr];
         rd_pend      = 1'b0;
      end
      if (pass_done_o) begin
         pd_seen   = pd_seen + 1;
         pd_at_acc = acc_cnt;
      end
      if (dbe_o) dbe_seen = dbe_seen + 1;
      if (mem_req_o) age = age + 1;
      else age = 0;
      mem_gnt_i = mem_req_o && (age > gnt_delay) && !rst_i;
      if (mem_gnt_i) begin
         acc_cnt      = acc_cnt + 1;
         prev_acc_cyc = last_acc_cyc;
         last_acc_cyc = cyc;
         obs = {mem_we_o, mem_addr_o, mem_we_o ? mem_wdata_o : CW'(0)};
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            failures = failures + 1;
            $display("FAIL access_unexpected: got we/addr/data=%h, required no access", obs);
         end else begin
            exp_v = exp_q.pop_front();
            if (obs !== exp_v) begin
               failures = failures + 1;
               $display("FAIL access_order: got we/addr/data=%h, required %h", obs, exp_v);
            end
         end
         if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
         else begin
            rd_pend = 1'b1;
            rd_addr = mem_addr_o;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      rst_i = 1'b1;
      en_i = 1'b0;
      clr_cnt_i = 1'b0;
      gnt_delay = 1;
      interval_i = 16'd0;
      for (int i = 0; i < DEPTH; i++) mem[i] = ref_enc(8'(i));
      repeat (3) @(negedge clk);
      #1;
      rst_i = 1'b0;
      exp_q.delete();
      acc_cnt  = 0;
      pd_seen  = 0;
      dbe_seen = 0;
      rd_pend  = 1'b0;
   endtask

   task automatic wait_acc(input int n, input string name);
      int t;
      t = 0;
      while (acc_cnt < n && t < 500) begin
         @(negedge clk);
         #1;
         t++;
      end
      checks++;
      if (acc_cnt < n) begin
         failures++;
         $display("FAIL %s_timeout: got %0d accesses, required %0d", name, acc_cnt, n);
      end
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      while (busy_o !== 1'b0 && t < 500) begin
         @(negedge clk);
         #1;
         t++;
      end
      checks++;
      if (busy_o !== 1'b0) begin
         failures++;
         $display("FAIL %s_idle_timeout: got busy=%b, required 0", name, busy_o);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, dbe_o, dbe_addr_o, pass_done_o} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got req=%b we=%b addr=%0d wdata=%h busy=%b dbe=%b dbe_addr=%0d pd=%b, required all 0",
                  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, dbe_o, dbe_addr_o, pass_done_o);
      end
      checks++;
      if (sbe_cnt_o !== 16'd0 || dbe_cnt_o !== 16'd0) begin
         failures++;
         $display("FAIL reset_counters: got sbe=%h dbe=%h, required 0", sbe_cnt_o, dbe_cnt_o);
      end
      // Reset while a read is outstanding.
      exp_q.push_back(mk(1'b0, 2'd0, '0));
      en_i = 1'b1;
      wait_acc(1, "reset_mid");
      en_i = 1'b0;
      @(posedge clk);
      #1;
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      checks++;
      if (mem_req_o !== 1'b0 || busy_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_op: got req=%b busy=%b, required 0 0", mem_req_o, busy_o);
      end
   endtask

   task automatic test_clean_pass();
      do_reset();
      interval_i = 16'd2;
      for (int i = 0; i < 5; i++) exp_q.push_back(mk(1'b0, AW'(i % DEPTH), '0));
      en_i = 1'b1;
      wait_acc(5, "clean");
      en_i = 1'b0;
      wait_idle("clean");
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL clean_pending: got %0d outstanding, required 0", exp_q.size());
      end
      checks++;
      if (pd_seen != 1 || pd_at_acc != 4) begin
         failures++;
         $display("FAIL clean_pass_done: got pulses=%0d after_access=%0d, required 1 after 4", pd_seen, pd_at_acc);
      end
      checks++;
      if (sbe_cnt_o !== 16'd0 || dbe_cnt_o !== 16'd0) begin
         failures++;
         $display("FAIL clean_counters: got sbe=%h dbe=%h, required 0 0", sbe_cnt_o, dbe_cnt_o);
      end
      checks++;
      if (last_acc_cyc - prev_acc_cyc != 8) begin
         failures++;
         $display("FAIL clean_spacing: got %0d cycles, required 8", last_acc_cyc - prev_acc_cyc);
      end
   endtask

   task automatic test_interval_zero();
      do_reset();
      interval_i = 16'd0;
      exp_q.push_back(mk(1'b0, 2'd0, '0));
      exp_q.push_back(mk(1'b0, 2'd1, '0));
      en_i = 1'b1;
      wait_acc(2, "ival0");
      en_i = 1'b0;
      wait_idle("ival0");
      checks++;
      if (last_acc_cyc - prev_acc_cyc != 6 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL ival0_spacing: got %0d cycles pending=%0d, required 6 0",
                  last_acc_cyc - prev_acc_cyc, exp_q.size());
      end
   endtask

   task automatic test_sbe_fix();
      do_reset();
      interval_i = 16'd1;
      mem[2] = ref_enc(8'hA5) ^ 13'h0020;
      exp_q.push_back(mk(1'b0, 2'd0, '0));
      exp_q.push_back(mk(1'b0, 2'd1, '0));
      exp_q.push_back(mk(1'b0, 2'd2, '0));
      exp_q.push_back(mk(1'b1, 2'd2, ref_enc(8'hA5)));
      exp_q.push_back(mk(1'b0, 2'd3, '0));
      exp_q.push_back(mk(1'b0, 2'd0, '0));
      exp_q.push_back(mk(1'b0, 2'd1, '0));
      exp_q.push_back(mk(1'b0, 2'd2, '0));
      en_i = 1'b1;
      wait_acc(8, "sbe");
      en_i = 1'b0;
      wait_idle("sbe");
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL sbe_pending: got %0d outstanding, required 0", exp_q.size());
      end
      checks++;
      if (sbe_cnt_o !== 16'd1 || dbe_cnt_o !== 16'd0) begin
         failures++;
         $display("FAIL sbe_counters: got sbe=%h dbe=%h, required 1 0", sbe_cnt_o, dbe_cnt_o);
      end
      checks++;
      if (mem[2] !== ref_enc(8'hA5)) begin
         failures++;
         $display("FAIL sbe_mem: got %h, required %h", mem[2], ref_enc(8'hA5));
      end
   endtask

   task automatic test_dbe();
      do_reset();
      interval_i = 16'd1;
      mem[1] = ref_enc(8'h3C) ^ 13'h0088;
      for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b0, AW'(i), '0));
      en_i = 1'b1;
      wait_acc(4, "dbe");
      en_i = 1'b0;
      wait_idle("dbe");
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL dbe_pending: got %0d outstanding, required 0", exp_q.size());
      end
      checks++;
      if (dbe_seen != 1) begin
         failures++;
         $display("FAIL dbe_pulse: got %0d pulse cycles, required 1", dbe_seen);
      end
      checks++;
      if (dbe_addr_o !== 2'd1) begin
         failures++;
         $display("FAIL dbe_addr: got %0d, required 1", dbe_addr_o);
      end
      checks++;
      if (dbe_cnt_o !== 16'd1 || sbe_cnt_o !== 16'd0) begin
         failures++;
         $display("FAIL dbe_counters: got dbe=%h sbe=%h, required 1 0", dbe_cnt_o, sbe_cnt_o);
      end
   endtask

   task automatic test_grant_stall();
      int t;
      do_reset();
      interval_i = 16'd1;
      gnt_delay = 10;
      exp_q.push_back(mk(1'b0, 2'd0, '0));
      en_i = 1'b1;
      t = 0;
      while (mem_req_o !== 1'b1 && t < 100) begin
         @(negedge clk);
         #1;
         t++;
      end
      // Dropping enable while a request is pending must not withdraw it.
      en_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b0, 2'd0}) begin
            failures++;
            $display("FAIL stall_hold[%0d]: got req=%b we=%b addr=%0d, required 1 0 0",
                     i, mem_req_o, mem_we_o, mem_addr_o);
         end
         @(negedge clk);
         #1;
      end
      wait_idle("stall");
      checks++;
      if (acc_cnt != 1 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL stall_reads: got %0d accesses pending=%0d, required 1 0", acc_cnt, exp_q.size());
      end
   endtask

   task automatic test_disable_mid();
      do_reset();
      interval_i = 16'd1;
      mem[3] = ref_enc(8'h5A) ^ 13'h0200;
      for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b0, AW'(i), '0));
      exp_q.push_back(mk(1'b1, 2'd3, ref_enc(8'h5A)));
      en_i = 1'b1;
      wait_acc(4, "dis");
      @(posedge clk);
      #1;
      en_i = 1'b0;
      wait_idle("dis");
      checks++;
      if (exp_q.size() != 0 || sbe_cnt_o !== 16'd1) begin
         failures++;
         $display("FAIL dis_writeback: got pending=%0d sbe=%h, required 0 1", exp_q.size(), sbe_cnt_o);
      end
      repeat (6) begin
         @(negedge clk);
         #1;
      end
      checks++;
      if (busy_o !== 1'b0 || acc_cnt != 5) begin
         failures++;
         $display("FAIL dis_idle: got busy=%b accesses=%0d, required 0 5", busy_o, acc_cnt);
      end
      acc_cnt = 0;
      pd_seen = 0;
      for (int i = 0; i < 5; i++) exp_q.push_back(mk(1'b0, AW'(i % DEPTH), '0));
      en_i = 1'b1;
      wait_acc(5, "resume");
      en_i = 1'b0;
      wait_idle("resume");
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL resume_pending: got %0d outstanding, required 0", exp_q.size());
      end
      checks++;
      if (pd_seen != 1 || pd_at_acc != 4) begin
         failures++;
         $display("FAIL resume_pass_done: got pulses=%0d after_access=%0d, required 1 after 4", pd_seen, pd_at_acc);
      end
   endtask

   task automatic test_counters();
      do_reset();
      interval_i = 16'd1;
      force dut.sbe_cnt_q = 16'hFFFF;
      @(posedge clk);
      #1;
      release dut.sbe_cnt_q;
      mem[0] = ref_enc(8'h11) ^ 13'h0001;
      mem[1] = ref_enc(8'h77) ^ 13'h1000;
      exp_q.push_back(mk(1'b0, 2'd0, '0));
      exp_q.push_back(mk(1'b1, 2'd0, ref_enc(8'h11)));
      exp_q.push_back(mk(1'b0, 2'd1, '0));
      exp_q.push_back(mk(1'b1, 2'd1, ref_enc(8'h77)));
      en_i = 1'b1;
      wait_acc(2, "sat");
      checks++;
      if (sbe_cnt_o !== 16'hFFFF) begin
         failures++;
         $display("FAIL sbe_saturate: got %h, required ffff", sbe_cnt_o);
      end
      wait_acc(3, "clr");
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      clr_cnt_i = 1'b1;
      @(posedge clk);
      #1;
      clr_cnt_i = 1'b0;
      checks++;
      if (sbe_cnt_o !== 16'd0) begin
         failures++;
         $display("FAIL clr_wins: got %h, required 0", sbe_cnt_o);
      end
      wait_acc(4, "clr_wb");
      en_i = 1'b0;
      wait_idle("clr");
      checks++;
      if (exp_q.size() != 0 || sbe_cnt_o !== 16'd0 || dbe_cnt_o !== 16'd0) begin
         failures++;
         $display("FAIL clr_final: got pending=%0d sbe=%h dbe=%h, required 0 0 0",
                  exp_q.size(), sbe_cnt_o, dbe_cnt_o);
      end
   endtask

   initial begin
      test_reset();
      test_clean_pass();
      test_interval_zero();
      test_sbe_fix();
      test_dbe();
      test_grant_stall();
      test_disable_mid();
      test_counters();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
